// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch-port, data-port and SRAM-side signals for mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the client/SRAM side.
interface mem_port_arbiter_if #(
  parameter int ADDRESS_LEN = 32
);
  logic                   if_req;
  logic [ADDRESS_LEN-1:0] if_addr;
  logic                   if_flush;
  logic [ADDRESS_LEN-1:0] if_rdata;
  logic                   if_ready;
  logic                   if_freeze;

  logic                   mem_rd;
  logic                   mem_wr;
  logic [ADDRESS_LEN-1:0] mem_addr;
  logic [ADDRESS_LEN-1:0] mem_wdata;
  logic [ADDRESS_LEN-1:0] mem_rdata;
  logic                   mem_ready;
  logic                   mem_freeze;

  logic                   sram_en;
  logic                   sram_we;
  logic [ADDRESS_LEN-1:0] sram_addr;
  logic [ADDRESS_LEN-1:0] sram_wdata;
  logic [ADDRESS_LEN-1:0] sram_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  sram_rdata,
    output if_rdata, if_ready, if_freeze,
    output mem_rdata, mem_ready, mem_freeze,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output sram_rdata,
    input  if_rdata, if_ready, if_freeze,
    input  mem_rdata, mem_ready, mem_freeze,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one fixed-latency SRAM.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention (default: data always wins).
module mem_port_arbiter #(
  parameter int ADDRESS_LEN  = 32,
  parameter int SRAM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] COUNT_LOAD = 4'(SRAM_LATENCY - 1);

  state_t                 state_reg, state_next;
  logic [3:0]             count_reg, count_next;
  logic                   grant_reg, grant_next;   // 1 = fetch port owns the access
  logic                   we_reg, we_next;
  logic                   flush_reg, flush_next;
  logic [ADDRESS_LEN-1:0] addr_reg, addr_next;
  logic [ADDRESS_LEN-1:0] wdata_reg, wdata_next;
  logic [ADDRESS_LEN-1:0] if_rdata_reg, if_rdata_next;
  logic [ADDRESS_LEN-1:0] mem_rdata_reg, mem_rdata_next;

  logic data_req;
  logic fetch_req;
  logic pick_fetch;

  assign data_req  = bus.mem_rd | bus.mem_wr;
  // A branch in the same cycle makes the presented fetch address stale.
  assign fetch_req = bus.if_req & ~bus.if_flush;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_reg, last_grant_next;   // 1 = fetch was served last

  assign pick_fetch = fetch_req & (~data_req | ~last_grant_reg);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_reg <= 1'b1;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    last_grant_next = last_grant_reg;
    if (state_reg == IDLE && (data_req || fetch_req)) begin
      last_grant_next = pick_fetch;
    end
  end
`else
  assign pick_fetch = fetch_req & ~data_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      grant_reg     <= 1'b0;
      we_reg        <= 1'b0;
      flush_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      grant_reg     <= grant_next;
      we_reg        <= we_next;
      flush_reg     <= flush_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      if_rdata_reg  <= if_rdata_next;
      mem_rdata_reg <= mem_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    grant_next     = grant_reg;
    we_next        = we_reg;
    flush_next     = flush_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    if_rdata_next  = if_rdata_reg;
    mem_rdata_next = mem_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (data_req || fetch_req) begin
          grant_next = pick_fetch;
          addr_next  = pick_fetch ? bus.if_addr : bus.mem_addr;
          wdata_next = bus.mem_wdata;
          we_next    = ~pick_fetch & bus.mem_wr;
          count_next = COUNT_LOAD;
          flush_next = 1'b0;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (grant_reg && bus.if_flush) begin
          flush_next = 1'b1;
        end
        if (count_reg == 4'd0) begin
          if (!we_reg) begin
            if (grant_reg) begin
              if_rdata_next = bus.sram_rdata;
            end else begin
              mem_rdata_next = bus.sram_rdata;
            end
          end
          state_next = RESP;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      RESP: begin
        flush_next = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  logic in_access;
  logic in_resp;

  // Gating with rst keeps strobes quiet for the whole reset cycle, not just after the edge.
  assign in_access = rst & (state_reg == ACCESS);
  assign in_resp   = rst & (state_reg == RESP);

  assign bus.sram_en    = in_access;
  assign bus.sram_we    = in_access & we_reg;
  assign bus.sram_addr  = addr_reg;
  assign bus.sram_wdata = wdata_reg;

  assign bus.if_ready   = in_resp & grant_reg & ~flush_reg & ~bus.if_flush;
  assign bus.mem_ready  = in_resp & ~grant_reg;
  assign bus.if_rdata   = if_rdata_reg;
  assign bus.mem_rdata  = mem_rdata_reg;

  assign bus.if_freeze  = bus.if_req & ~bus.if_ready;
  assign bus.mem_freeze = (bus.mem_rd | bus.mem_wr) & ~bus.mem_ready;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDRESS_LEN, default 32, address and data width in bits.
REQ-002 Parameter SRAM_LATENCY, default 2, SRAM access cycles; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 if_req  input  1  instruction fetch request; held until if_ready.
REQ-006 if_addr  input  ADDRESS_LEN  fetch address, stable while if_req=1.
REQ-007 if_flush  input  1  branch taken; abandons the fetch in flight.
REQ-008 if_rdata  output  ADDRESS_LEN  fetched instruction, valid when if_ready=1.
REQ-009 if_ready  output  1  one-cycle fetch completion pulse.
REQ-010 if_freeze  output  1  stall for the fetch stage PC register.
REQ-011 mem_rd / mem_wr  input  1 each  data-stage read / write request; held until mem_ready.
REQ-012 mem_addr / mem_wdata  input  ADDRESS_LEN each  data address / write data.
REQ-013 mem_rdata  output  ADDRESS_LEN  read data, valid when mem_ready=1.
REQ-014 mem_ready  output  1  one-cycle data completion pulse.
REQ-015 mem_freeze  output  1  stall for the whole pipeline.
REQ-016 sram_en / sram_we  output  1 each  SRAM enable / write enable.
REQ-017 sram_addr / sram_wdata  output  ADDRESS_LEN each  SRAM address / write data.
REQ-018 sram_rdata  input  ADDRESS_LEN  SRAM read data, valid in the last access cycle.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-020 IDLE: requests sampled at each edge; on any request, load the grant, latch address, data and direction, load the counter with SRAM_LATENCY-1, and go to ACCESS.
REQ-021 ACCESS: sram_en=1 and address, data and we held from latched values; the counter decrements each cycle; at count 0 capture sram_rdata (reads) and go to RESP.
REQ-022 RESP: exactly one cycle; pulse the granted requester's ready and drive its rdata from the capture register; return to IDLE without sampling requests.
REQ-023 Latency SHALL be: request sampled at edge N, ready high in cycle N+SRAM_LATENCY+1; one access per SRAM_LATENCY+2 cycles.
REQ-024 Default priority SHALL be fixed: data request wins over a simultaneous fetch request.
REQ-025 mem_rd and mem_wr both high SHALL be treated as a write; the read is ignored.
REQ-026 Writes SHALL pulse mem_ready in RESP; mem_rdata is unchanged on a write.
REQ-027 if_flush during ACCESS or RESP of a fetch SHALL let the SRAM access complete but suppress if_ready; the flag clears on return to IDLE.
REQ-028 if_flush in IDLE SHALL block the fetch grant for that edge; a data request in the same cycle is still granted.
REQ-029 if_freeze SHALL be combinational if_req & ~if_ready; mem_freeze SHALL be (mem_rd|mem_wr) & ~mem_ready.
REQ-030 if_rdata and mem_rdata SHALL hold their last captured value outside RESP.
REQ-031 sram_en and sram_we SHALL be 0 in IDLE and RESP.

Reset
REQ-032 With rst=0 at an edge, the FSM SHALL go to IDLE, the counter, grant and flush flag SHALL clear, and rdata registers SHALL clear to 0.
REQ-033 During reset, sram_en, sram_we, if_ready and mem_ready SHALL be 0; an access in flight is dropped with no ready pulse.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not served by the previous grant; the last-grant bit resets to "fetch", so data wins first.
REQ-035 Macro ARB_ROUND_ROBIN_EN undefined: fixed data priority per REQ-024; no last-grant state.

Verification
REQ-036 Fetch only, if_addr=0x100, latency 2, sram returns 0xE3A01005 -> sram_en high for cycles 1-2, if_ready in cycle 3, if_rdata=0xE3A01005.
REQ-037 mem_wr=1, mem_addr=0x400, mem_wdata=0xDEADBEEF, simultaneous if_req -> write served first (sram_we=1, addr 0x400), mem_ready in cycle 3, fetch granted next, if_ready in cycle 7.
REQ-038 if_flush pulsed in the second ACCESS cycle of a fetch from 0x200 -> no if_ready; next fetch to 0x300 is served normally.
REQ-039 rst=0 asserted mid-ACCESS of a read -> next cycle sram_en=0, no mem_ready; after release the held request restarts from IDLE.
REQ-040 ARB_ROUND_ROBIN_EN defined, if_req and mem_rd held continuously -> grants alternate data, fetch, data, fetch.
REQ-041 mem_rd=mem_wr=1 -> sram_we=1 during access; mem_rdata unchanged after mem_ready.
